// File: rtl/reg_bi_pkg.sv
// Shared CPU datapath package: width constant and BI/AI source selects.
// Also holds the strobe priority encoder used by the operand registers.
package reg_bi_pkg;

  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    BI_SRC_NONE   = 2'd0,
    BI_SRC_DB     = 2'd1,
    BI_SRC_INV_DB = 2'd2,
    BI_SRC_ADL    = 2'd3
  } bi_src_e;

  // DB wins over inverted DB, which wins over ADL.
  function automatic bi_src_e bi_src_sel(
    input logic db_ld,
    input logic inv_ld,
    input logic adl_ld
  );
    bi_src_e s;
    if (db_ld)       s = BI_SRC_DB;
    else if (inv_ld) s = BI_SRC_INV_DB;
    else if (adl_ld) s = BI_SRC_ADL;
    else             s = BI_SRC_NONE;
    return s;
  endfunction

endpackage

// File: rtl/reg_bi_src_mux.sv
// Operand source mux: picks DB, ~DB or ADL; falls back to the held value.
// Shared shape with the AI register.
module reg_bi_src_mux
  import reg_bi_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  bi_src_e           sel_i,
  input  logic [WIDTH-1:0]  db_i,
  input  logic [WIDTH-1:0]  adl_i,
  input  logic [WIDTH-1:0]  hold_i,
  output logic [WIDTH-1:0]  data_o
);

  always_comb begin
    data_o = hold_i;
    case (sel_i)
      BI_SRC_DB:     data_o = db_i;
      BI_SRC_INV_DB: data_o = ~db_i;
      BI_SRC_ADL:    data_o = adl_i;
      default:       data_o = hold_i;
    endcase
  end

endmodule

// File: rtl/reg_bi.sv
// BI holding register: second ALU operand, loaded from DB, ~DB or ADL.
// Output comes straight from the flop; no input reaches TO_ALU combinationally.
module reg_bi
  import reg_bi_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              DB_LOAD,
  input  logic              INV_DB_LOAD,
  input  logic              ADL_LOAD,
  input  logic [WIDTH-1:0]  ADL_DATA,
  input  logic [WIDTH-1:0]  DB_DATA,
  input  logic [WIDTH-1:0]  INV_DB_DATA,
  output logic [WIDTH-1:0]  TO_ALU
);

  bi_src_e          sel;
  logic [WIDTH-1:0] bi_d;
  logic [WIDTH-1:0] bi_q;
  logic             unused_inv_db;

  // The inverted bus is formed locally; the external copy is ignored.
  assign unused_inv_db = ^INV_DB_DATA;

  assign sel = bi_src_sel(DB_LOAD, INV_DB_LOAD, ADL_LOAD);

  reg_bi_src_mux #(
    .WIDTH (WIDTH)
  ) u_mux (
    .sel_i  (sel),
    .db_i   (DB_DATA),
    .adl_i  (ADL_DATA),
    .hold_i (bi_q),
    .data_o (bi_d)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) bi_q <= '0;
    else     bi_q <= bi_d;
  end

  assign TO_ALU = bi_q;

endmodule

// File: tb/tb_reg_bi.sv
// Self-checking bench for reg_bi: directed plan items, then random
// stimulus against a behavioural operand-register model.
module tb_reg_bi;

  logic       clk = 1'b0;
  logic       rst;
  logic       db_ld, inv_ld, adl_ld;
  logic [7:0] adl, db, inv_db;
  logic [7:0] to_alu;

  int total = 0;
  int bad   = 0;
  logic [7:0] m;

  always #5 clk = ~clk;

  reg_bi #(.WIDTH(8)) dut (
    .CLK         (clk),
    .RST         (rst),
    .DB_LOAD     (db_ld),
    .INV_DB_LOAD (inv_ld),
    .ADL_LOAD    (adl_ld),
    .ADL_DATA    (adl),
    .DB_DATA     (db),
    .INV_DB_DATA (inv_db),
    .TO_ALU      (to_alu)
  );

  task automatic chk(input string tag, input logic [7:0] got,
                     input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_in(input logic d, input logic i, input logic a,
                        input logic [7:0] dbv, input logic [7:0] adlv,
                        input logic [7:0] ivv);
    db_ld = d; inv_ld = i; adl_ld = a;
    db = dbv; adl = adlv; inv_db = ivv;
  endtask

  // Advance one edge, update the model from the sampled inputs, check.
  task automatic tick(input string tag);
    @(posedge clk);
    if (rst)         m = 8'h00;
    else if (db_ld)  m = db;
    else if (inv_ld) m = 8'hFF ^ db;
    else if (adl_ld) m = adl;
    #1;
    chk(tag, to_alu, m);
  endtask

  initial begin
    rst = 1'b1;
    set_in(1, 0, 0, 8'hAA, 8'h00, 8'h00);
    m = 8'h00;
    #1;
    chk("rst_imm", to_alu, 8'h00);
    tick("rst_e1");
    tick("rst_e2");
    rst = 1'b0;
    set_in(0, 0, 0, 8'hAA, 8'h00, 8'h00);
    tick("rst_idle");

    set_in(1, 0, 0, 8'hAA, 8'hBB, 8'h00);
    tick("db_load");
    chk("db_val", to_alu, 8'hAA);
    set_in(0, 0, 0, 8'h12, 8'hBB, 8'h00);
    for (int k = 0; k < 3; k++) tick("db_hold");
    chk("db_hold_val", to_alu, 8'hAA);

    set_in(0, 1, 0, 8'hAA, 8'hBB, 8'h00);
    tick("inv_load0");
    chk("inv_val0", to_alu, 8'h55);
    set_in(0, 0, 0, 8'h00, 8'hBB, 8'h00);
    tick("inv_idle");
    set_in(0, 1, 0, 8'hAA, 8'hBB, 8'hFF);
    tick("inv_loadF");
    chk("inv_valF", to_alu, 8'h55);

    set_in(0, 0, 1, 8'hAA, 8'hBB, 8'h00);
    tick("adl_load");
    chk("adl_val", to_alu, 8'hBB);
    set_in(0, 0, 0, 8'h3C, 8'h00, 8'h00);
    tick("adl_hold");
    chk("adl_hold_val", to_alu, 8'hBB);

    set_in(1, 1, 1, 8'h0F, 8'hC3, 8'h00);
    tick("pri_all");
    chk("pri_all_val", to_alu, 8'h0F);
    set_in(0, 1, 1, 8'h0F, 8'hC3, 8'h00);
    tick("pri_inv_adl");
    chk("pri_inv_adl_val", to_alu, 8'hF0);
    set_in(0, 0, 1, 8'h0F, 8'hC3, 8'h00);
    tick("pri_adl");
    chk("pri_adl_val", to_alu, 8'hC3);

    set_in(0, 1, 0, 8'hAA, 8'h00, 8'h00);
    tick("pre_arst");
    chk("pre_arst_val", to_alu, 8'h55);
    set_in(1, 0, 0, 8'h77, 8'h00, 8'h00);
    #2;
    rst = 1'b1;
    m = 8'h00;
    #1;
    chk("arst_imm", to_alu, 8'h00);
    tick("arst_e1");
    tick("arst_e2");
    rst = 1'b0;
    set_in(0, 0, 0, 8'h77, 8'h00, 8'h00);
    tick("arst_rel");
    chk("arst_rel_val", to_alu, 8'h00);

    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 39) == 0);
      set_in($urandom_range(0, 9) < 3, $urandom_range(0, 9) < 3,
             $urandom_range(0, 9) < 3, 8'($urandom), 8'($urandom),
             8'($urandom));
      tick("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
